// File: rtl/mips_soc_pkg.sv
// Shared definitions for the MIPS32 SOC test-harness blocks: run-monitor
// state encoding, GPR constants and the layout of the fault-cause vector.
package mips_soc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } run_state_t;

  // $0 is hard-wired to zero in the core
  localparam logic [4:0] GPR_ZERO = 5'd0;

  // Cause vector is {iOp, iAddr, invpc, error}. The error field starts at
  // ERR_BASE; the three flag positions are offsets above the error field.
  localparam int ERR_BASE = 0;
  localparam int INVPC    = 0;
  localparam int IADDR    = 1;
  localparam int IOP      = 2;

  // Watch slots 0..3 = $t0..$t3
  localparam logic [19:0] DEFAULT_WATCH_LIST = {5'd11, 5'd10, 5'd9, 5'd8};

endpackage

// File: rtl/mips_watch_slot.sv
// One shadow slot: mirrors a single GPR from the register-file write port.
// A slot watching $0 reads constant 0 with valid set and ignores writes.
module mips_watch_slot
  import mips_soc_pkg::*;
#(
  parameter int         DATA_W = 32,
  parameter logic [4:0] IDX    = 5'd8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              i_freeze,
  input  logic              i_we,
  input  logic [4:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_val,
  output logic              o_valid
);

  generate
    if (IDX == GPR_ZERO) begin : g_zero
      logic w_unused;
      assign w_unused = ^{reset, i_freeze, i_we, i_waddr, i_wdata};
      assign o_val    = '0;
      assign o_valid  = 1'b1;
    end else begin : g_reg
      logic [DATA_W-1:0] r_val;
      logic              r_valid;
      logic              w_hit;

      assign w_hit = !i_freeze && i_we && (i_waddr == IDX);

      // Capture matching writes while the monitor is running
      always_ff @(posedge CLK) begin
        if (reset) begin
          r_val   <= '0;
          r_valid <= 1'b0;
        end else if (w_hit) begin
          r_val   <= i_wdata;
          r_valid <= 1'b1;
        end
      end

      assign o_val   = r_val;
      assign o_valid = r_valid;
    end
  endgenerate

endmodule

// File: rtl/mips_run_monitor.sv
// Run monitor for MIPS32 instruction tests: shadows watched GPRs, detects
// a PC parked on a jump-to-self, and latches the first fault with its PC.
// Optional cycle counter: define MIPS_RUN_MONITOR_CYCLES_EN.
module mips_run_monitor
  import mips_soc_pkg::*;
#(
  parameter int                     NUM_WATCH   = 4,
  parameter int                     DATA_W      = 32,
  parameter int                     ERR_W       = 11,
  parameter int                     HALT_CYCLES = 4,
  parameter int                     CNT_W       = 32,
  parameter logic [NUM_WATCH*5-1:0] WATCH_LIST  = DEFAULT_WATCH_LIST
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic [31:0]                 pc,
  input  logic                        rf_we,
  input  logic [4:0]                  rf_waddr,
  input  logic [DATA_W-1:0]           rf_wdata,
  input  logic                        invpc,
  input  logic                        iAddr,
  input  logic                        iOp,
  input  logic [ERR_W-1:0]            error,
  output logic [NUM_WATCH*DATA_W-1:0] w_val,
  output logic [NUM_WATCH-1:0]        w_valid,
  output logic [1:0]                  state,
  output logic                        halt,
  output logic                        fault,
  output logic [31:0]                 fault_pc,
  output logic [ERR_W+2:0]            fault_cause
`ifdef MIPS_RUN_MONITOR_CYCLES_EN
  ,
  output logic [CNT_W-1:0]            cycles
`endif
);

  localparam int CAUSE_W = ERR_W + 3;
  localparam int STALL_W = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(HALT_CYCLES - 1);

  run_state_t         r_state, w_state_next;
  logic [31:0]        r_prev_pc;
  logic               r_first;
  logic [STALL_W-1:0] r_stall;
  logic [31:0]        r_fault_pc;
  logic [CAUSE_W-1:0] r_fault_cause;

  logic [CAUSE_W-1:0] w_cause;
  logic               w_run;
  logic               w_fault_now;
  logic               w_pc_same;
  logic               w_halt_now;

  always_comb begin
    w_cause                   = '0;
    w_cause[ERR_BASE +: ERR_W] = error;
    w_cause[ERR_W + INVPC]    = invpc;
    w_cause[ERR_W + IADDR]    = iAddr;
    w_cause[ERR_W + IOP]      = iOp;
  end

  assign w_run       = (r_state == ST_RUN);
  assign w_fault_now = w_run && (|w_cause);
  // The first RUN cycle only seeds the previous-PC register
  assign w_pc_same   = !r_first && (pc == r_prev_pc);
  assign w_halt_now  = w_run && w_pc_same && (r_stall == STALL_LAST);

  // State register
  always_ff @(posedge CLK) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state: fault beats halt; HALTED and FAULT are absorbing
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: w_state_next = ST_RUN;
      ST_RUN: begin
        if (w_fault_now)     w_state_next = ST_FAULT;
        else if (w_halt_now) w_state_next = ST_HALTED;
      end
      default: w_state_next = r_state;
    endcase
  end

  // Previous-PC tracking and stall counter, active only in RUN
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_prev_pc <= '0;
      r_first   <= 1'b1;
      r_stall   <= '0;
    end else if (w_run) begin
      r_prev_pc <= pc;
      r_first   <= 1'b0;
      r_stall   <= w_pc_same ? r_stall + 1'b1 : '0;
    end
  end

  // First-fault capture
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_fault_pc    <= '0;
      r_fault_cause <= '0;
    end else if (w_fault_now) begin
      r_fault_pc    <= pc;
      r_fault_cause <= w_cause;
    end
  end

`ifdef MIPS_RUN_MONITOR_CYCLES_EN
  logic [CNT_W-1:0] r_cycles;

  // Saturating count of RUN cycles
  always_ff @(posedge CLK) begin
    if (reset)                  r_cycles <= '0;
    else if (w_run && !(&r_cycles)) r_cycles <= r_cycles + 1'b1;
  end

  assign cycles = r_cycles;
`endif

  // Shadow slots; a write coinciding with a fault is dropped
  generate
    for (genvar gi = 0; gi < NUM_WATCH; gi++) begin : g_slot
      mips_watch_slot #(
        .DATA_W (DATA_W),
        .IDX    (WATCH_LIST[5*gi +: 5])
      ) u_slot (
        .CLK      (CLK),
        .reset    (reset),
        .i_freeze (!w_run),
        .i_we     (rf_we && !w_fault_now),
        .i_waddr  (rf_waddr),
        .i_wdata  (rf_wdata),
        .o_val    (w_val[DATA_W*gi +: DATA_W]),
        .o_valid  (w_valid[gi])
      );
    end
  endgenerate

  assign state       = r_state;
  assign halt        = (r_state == ST_HALTED);
  assign fault       = (r_state == ST_FAULT);
  assign fault_pc    = r_fault_pc;
  assign fault_cause = r_fault_cause;

endmodule
